// File: rtl/poly1305_msg_formatter.sv
// poly1305_msg_formatter: packs AAD and CT bytes into zero-padded 128-bit Poly1305 blocks plus the length block
module poly1305_msg_formatter #(
  parameter int LEN_W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         ad_nil,
  input  logic         ct_nil,
  input  logic         dat_v,
  input  logic [7:0]   dat,
  input  logic         dat_t,
  input  logic         dat_l,
  output logic         dat_r,
  output logic         blk_v,
  output logic [127:0] blk,
  output logic         blk_l,
  input  logic         blk_r,
  output logic         busy,
  output logic         err
);
  typedef enum logic [2:0] {IDLE, AAD, CT, EMIT, LEN, DONE} state_t;
  localparam int PAD = 64 - LEN_W;
  state_t state_q, state_d, ret_q, ret_d;
  logic [127:0] acc_q, acc_d;
  logic [3:0] idx_q, idx_d;
  logic [LEN_W-1:0] ad_cnt_q, ad_cnt_d, ct_cnt_q, ct_cnt_d, cnt;
  logic err_q, err_d, ct_nil_q, ct_nil_d, sec_ct, take;
  assign dat_r = state_q == AAD || state_q == CT;
  assign blk_v = state_q == EMIT || state_q == LEN;
  assign blk_l = state_q == LEN;
  assign blk = state_q == EMIT ? acc_q :
               state_q == LEN  ? {{PAD{1'b0}}, ct_cnt_q, {PAD{1'b0}}, ad_cnt_q} : '0;
  assign busy = state_q != IDLE && state_q != DONE;
  assign err = err_q;
  assign sec_ct = state_q == CT;
  assign take = dat_v && dat_r;
  assign cnt = sec_ct ? ct_cnt_q : ad_cnt_q;
  // next state: start always restarts; bytes fill lanes, a full or final lane hands off to EMIT
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    acc_d = acc_q;
    idx_d = idx_q;
    ad_cnt_d = ad_cnt_q;
    ct_cnt_d = ct_cnt_q;
    err_d = err_q;
    ct_nil_d = ct_nil_q;
    if (start) begin
      state_d = !ad_nil ? AAD : !ct_nil ? CT : LEN;
      ret_d = IDLE;
      acc_d = '0;
      idx_d = '0;
      ad_cnt_d = '0;
      ct_cnt_d = '0;
      err_d = 1'b0;
      ct_nil_d = ct_nil;
    end else begin
      case (state_q)
        AAD, CT: if (take) begin
          if (dat_t != sec_ct) err_d = 1'b1;
          else begin
            acc_d[{idx_q, 3'b000} +: 8] = dat;
            idx_d = idx_q + 4'd1;
            if (&cnt) err_d = 1'b1;
            else if (sec_ct) ct_cnt_d = ct_cnt_q + LEN_W'(1);
            else ad_cnt_d = ad_cnt_q + LEN_W'(1);
            if (idx_q == 4'd15 || dat_l) begin
              state_d = EMIT;
              ret_d = !dat_l ? state_q : (sec_ct || ct_nil_q) ? LEN : CT;
            end
          end
        end
        EMIT: if (blk_r) begin
          acc_d = '0;
          idx_d = '0;
          state_d = ret_q;
        end
        LEN: state_d = blk_r ? DONE : LEN;
        DONE: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      acc_q <= '0;
      idx_q <= '0;
      ad_cnt_q <= '0;
      ct_cnt_q <= '0;
      err_q <= 1'b0;
      ct_nil_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      ad_cnt_q <= ad_cnt_d;
      ct_cnt_q <= ct_cnt_d;
      err_q <= err_d;
      ct_nil_q <= ct_nil_d;
    end
  end
endmodule

// File: tb/tb_poly1305_msg_formatter.sv
// tb_poly1305_msg_formatter: directed checks of block formatting, padding, backpressure, abort and reset
module tb_poly1305_msg_formatter;
  logic clk = 1'b0;
  logic rst, start, ad_nil, ct_nil, dat_v, dat_t, dat_l, dat_r;
  logic [7:0] dat;
  logic blk_v, blk_l, blk_r, busy, err;
  logic [127:0] blk;
  int n_chk = 0, n_fail = 0, cyc = 0, last_acc = 0, first_rise = -1, hold = 0;
  bit bp = 1'b0;
  logic [128:0] got_q[$], exp_q[$];
  logic [7:0] ad_buf[32], ct_buf[128];
  logic [911:0] rfc;

  poly1305_msg_formatter dut (
    .clk(clk), .rst(rst), .start(start), .ad_nil(ad_nil), .ct_nil(ct_nil),
    .dat_v(dat_v), .dat(dat), .dat_t(dat_t), .dat_l(dat_l), .dat_r(dat_r),
    .blk_v(blk_v), .blk(blk), .blk_l(blk_l), .blk_r(blk_r), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // downstream sink: optional 5-cycle stall per block, hold and dat_r checks, records taken blocks
  initial begin
    logic [128:0] prev;
    bit prev_pend, prev_v;
    blk_r = 1'b0;
    prev = '0;
    prev_pend = 1'b0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_v && prev_pend) chk("hold", {blk_l, blk}, prev);
      if (blk_v) chk("dat_r_low", dat_r, 0);
      if (blk_v && !prev_v && first_rise < 0) first_rise = cyc;
      if (!blk_v) begin
        blk_r = 1'b0;
        hold = 0;
      end else if (bp && hold < 5) begin
        blk_r = 1'b0;
        hold++;
      end else begin
        blk_r = 1'b1;
        hold = 0;
        got_q.push_back({blk_l, blk});
      end
      prev_pend = blk_v && !blk_r;
      prev = {blk_l, blk};
      prev_v = blk_v;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input bit adn, input bit ctn);
    start = 1'b1;
    ad_nil = adn;
    ct_nil = ctn;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit t, input bit l);
    int n = 0;
    dat_v = 1'b1;
    dat = b;
    dat_t = t;
    dat_l = l;
    @(negedge clk);
    while (!dat_r && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dat_r) chk("send_timeout", dat_r, 1);
    last_acc = cyc;
    tick();
    dat_v = 1'b0;
  endtask

  task automatic wait_idle(input bit chk_dr);
    int n = 0;
    do begin
      @(negedge clk);
      if (chk_dr) chk("dat_r_nil", dat_r, 0);
      n++;
    end while (busy && n < 2000);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic build_exp(input int na, input int nc);
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      int n = s ? nc : na;
      for (int b = 0; b < (n + 15) / 16; b++) begin
        logic [127:0] v = '0;
        for (int k = 0; k < 16 && b * 16 + k < n; k++)
          v[8*k +: 8] = s ? ct_buf[b*16+k] : ad_buf[b*16+k];
        exp_q.push_back({1'b0, v});
      end
    end
    exp_q.push_back({1'b1, 64'(nc), 64'(na)});
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nblk"}, 129'(got_q.size()), 129'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic run(input string tag, input int na, input int nc, input bit chk_drop, input bit chk_dr);
    int acc16 = -1;
    got_q.delete();
    first_rise = -1;
    start_msg(na == 0, nc == 0);
    if (chk_drop) chk("abort_drop", blk_v, 0);
    for (int i = 0; i < na; i++) begin
      send(ad_buf[i], 1'b0, i == na - 1);
      if (i == 15) acc16 = last_acc;
    end
    for (int i = 0; i < nc; i++) send(ct_buf[i], 1'b1, i == nc - 1);
    wait_idle(chk_dr);
    build_exp(na, nc);
    compare(tag);
    if (na >= 16) chk({tag, "_lat"}, 129'(first_rise - acc16), 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ad_nil = 1'b0;
    ct_nil = 1'b0;
    dat_v = 1'b0;
    dat = '0;
    dat_t = 1'b0;
    dat_l = 1'b0;
    repeat (3) tick();
    chk("rst_ctl", {blk_v, blk_l, dat_r, busy, err}, 0);
    chk("rst_blk", blk, 0);
    rst = 1'b0;
    tick();

    rfc = {128'hd31a8d34_648e60db_7b86afbc_53ef7ec2, 128'ha4aded51_296e08fe_a9e2b5a7_36ee62d6,
           128'h3dbea45e_8ca96712_82fafb69_da92728b, 128'h1a71de0a_9e060b29_05d6a5b6_7ecd3b36,
           128'h92ddbd7f_2d778b8c_9803aee3_28091b58, 128'hfab324e4_fad67594_5585808b_4831d7bc,
           128'h3ff4def0_8e4b7a9d_e576d265_86cec64b, 16'h6116};
    for (int i = 0; i < 114; i++) ct_buf[i] = rfc[911-8*i -: 8];
    ad_buf[0] = 8'h50;
    ad_buf[1] = 8'h51;
    ad_buf[2] = 8'h52;
    ad_buf[3] = 8'h53;
    for (int i = 0; i < 8; i++) ad_buf[4+i] = 8'hc0 + 8'(i);
    run("rfc", 12, 114, 1'b0, 1'b0);
    chk("rfc_aad", got_q[0], {1'b0, 128'h00000000_c7c6c5c4c3c2c1c0_53525150});
    chk("rfc_ct_tail", got_q[8], {1'b0, 112'h0, 16'h1661});
    chk("rfc_len", got_q[9], {1'b1, 64'h72, 64'h0c});

    for (int i = 0; i < 32; i++) ad_buf[i] = 8'(3 * i + 1);
    for (int i = 0; i < 128; i++) ct_buf[i] = ~8'(i);

    run("empty", 0, 0, 1'b0, 1'b1);
    chk("empty_len", got_q[0], {1'b1, 128'h0});

    run("aad16", 16, 0, 1'b0, 1'b0);
    chk("aad16_len", got_q[1], {1'b1, 64'h0, 64'd16});

    bp = 1'b1;
    run("bp", 20, 3, 1'b0, 1'b0);
    bp = 1'b0;

    got_q.delete();
    start_msg(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(ad_buf[i], 1'b0, 1'b0);
    send(8'hee, 1'b1, 1'b0);
    chk("err_set", err, 1);
    send(ad_buf[3], 1'b0, 1'b0);
    send(ad_buf[4], 1'b0, 1'b1);
    wait_idle(1'b0);
    build_exp(5, 0);
    compare("mism");
    chk("mism_len", got_q[1], {1'b1, 64'h0, 64'd5});
    chk("err_sticky", err, 1);
    start_msg(1'b1, 1'b1);
    chk("err_clr", err, 0);
    wait_idle(1'b0);

    bp = 1'b1;
    got_q.delete();
    start_msg(1'b0, 1'b0);
    send(ad_buf[0], 1'b0, 1'b0);
    send(ad_buf[1], 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send(ct_buf[i], 1'b1, 1'b0);
    for (int n = 0; n < 50 && !blk_v; n++) @(negedge clk);
    chk("abort_pend", {blk_v, 128'(got_q.size())}, {1'b1, 128'd1});
    run("abort", 3, 2, 1'b1, 1'b0);
    bp = 1'b0;

    got_q.delete();
    start_msg(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(ad_buf[i], 1'b0, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    chk("pre_rst_err", err, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ctl", {blk_v, blk_l, dat_r, busy, err}, 0);
    chk("mid_rst_blk", blk, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_noblk", 129'(got_q.size()), 0);

    run("recover", 5, 17, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
